// File: rtl/stream_writer_arbiter.sv
// Round-robin arbiter sharing one stb/ack sink between NUM_SRC producer streams.
// One word in flight: grant, capture, forward with a source tag, count deliveries.
module stream_writer_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int WIDTH   = 32,
  parameter int SRC_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*WIDTH-1:0] in_data,
  input  logic [NUM_SRC-1:0]       in_stb,
  output logic [NUM_SRC-1:0]       in_ack,
  output logic [WIDTH-1:0]         output_z,
  output logic [SRC_W-1:0]         output_z_src,
  output logic                     output_z_stb,
  input  logic                     output_z_ack,
  output logic [31:0]              words_sent
);

  // state  | meaning
  // IDLE   | no word held, looking for a requester
  // ACCEPT | in_ack[grant] raised, waiting for the producer's word
  // SEND   | word held on output_z, waiting for the sink
  typedef enum logic [1:0] {IDLE, ACCEPT, SEND} state_t;

  state_t             state;
  logic [SRC_W-1:0]   grant;
  logic [SRC_W-1:0]   last;
  logic [SRC_W-1:0]   pick;
  logic               pick_vld;

  // Scan downward so the requester closest after 'last' is assigned last and wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      logic [SRC_W-1:0] idx;
      idx = SRC_W'((int'(last) + i) % NUM_SRC);
      if (in_stb[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      grant        <= '0;
      last         <= SRC_W'(NUM_SRC - 1);
      in_ack       <= '0;
      output_z     <= '0;
      output_z_src <= '0;
      output_z_stb <= 1'b0;
      words_sent   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant  <= pick;
            in_ack <= NUM_SRC'(1) << pick;
            state  <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (in_stb[grant]) begin
            output_z     <= in_data[int'(grant)*WIDTH +: WIDTH];
            output_z_src <= grant;
            output_z_stb <= 1'b1;
            in_ack       <= '0;
            state        <= SEND;
          end
        end
        SEND: begin
          if (output_z_ack) begin
            output_z_stb <= 1'b0;
            last         <= grant;
            words_sent   <= words_sent + 32'd1;
            state        <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          in_ack <= '0;
        end
      endcase
    end
  end

endmodule
